// File: rtl/bus_bridge_initiator_uart_link.sv
// Far end of the bridge serial link: 4-byte UART request frames -> valid/ready request port,
// response -> 2-byte UART frame. Optional inter-byte timeout under BRIDGE_FRAME_TIMEOUT_EN.
module bus_bridge_initiator_uart_link #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_byte,
  input  logic        rx_ready,
  output logic        rx_ready_clr,
  output logic [7:0]  tx_byte,
  output logic        tx_wr_en,
  input  logic        tx_busy,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [15:0] req_addr,
  output logic [7:0]  req_wdata,
  output logic        req_is_write,
  input  logic        resp_valid,
  output logic        resp_ready,
  input  logic [7:0]  resp_rdata,
  input  logic        resp_is_write,
  output logic        frame_err,
  output logic [7:0]  frames_done
);
  typedef enum logic [2:0] {RX_B0, RX_B1, RX_B2, RX_B3, RX_HOLD, RX_WAIT_RESP} rx_state_t;
  typedef enum logic [2:0] {TX_IDLE, TX_SEND_DATA, TX_WAIT_DATA, TX_SEND_FLAGS, TX_WAIT_FLAGS} tx_state_t;

  rx_state_t rx_state, rx_next;
  tx_state_t tx_state, tx_next;
  logic       rx_fill, consume, timeout;
  logic       tx_busy_d, busy_fall, tx_done, resp_hs;
  logic [7:0] rdata_q;
  logic       is_write_q;

  assign rx_fill   = rx_state inside {RX_B0, RX_B1, RX_B2, RX_B3};
  // rx_ready_clr high means the uart has not yet dropped rx_ready for the last byte
  assign consume   = rx_fill && rx_ready && !rx_ready_clr;
  assign busy_fall = tx_busy_d && !tx_busy;
  assign tx_done   = (tx_state == TX_WAIT_FLAGS) && busy_fall;
  assign resp_hs   = (tx_state == TX_IDLE) && resp_valid && resp_ready;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rx_state <= RX_B0;
      tx_state <= TX_IDLE;
    end else begin
      rx_state <= rx_next;
      tx_state <= tx_next;
    end

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_B0:        if (consume) rx_next = RX_B1;
      RX_B1:        if (consume) rx_next = RX_B2;
      RX_B2:        if (consume) rx_next = RX_B3;
      RX_B3:        if (consume) rx_next = RX_HOLD;
      RX_HOLD:      if (req_valid && req_ready) rx_next = RX_WAIT_RESP;
      RX_WAIT_RESP: if (tx_done) rx_next = RX_B0;
      default:      rx_next = RX_B0;
    endcase
    if (timeout) rx_next = RX_B0;
  end

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      TX_IDLE:       if (resp_hs) tx_next = TX_SEND_DATA;
      TX_SEND_DATA:  if (!tx_busy) tx_next = TX_WAIT_DATA;
      TX_WAIT_DATA:  if (busy_fall) tx_next = TX_SEND_FLAGS;
      TX_SEND_FLAGS: if (!tx_busy) tx_next = TX_WAIT_FLAGS;
      TX_WAIT_FLAGS: if (busy_fall) tx_next = TX_IDLE;
      default:       tx_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rx_ready_clr <= 1'b0;
      req_valid    <= 1'b0;
      req_addr     <= '0;
      req_wdata    <= '0;
      req_is_write <= 1'b0;
    end else begin
      rx_ready_clr <= consume;
      req_valid    <= (rx_next == RX_HOLD);
      if (consume)
        case (rx_state)
          RX_B0:   req_addr[7:0]  <= rx_byte;
          RX_B1:   req_addr[15:8] <= rx_byte;
          RX_B2:   req_wdata      <= rx_byte;
          RX_B3:   req_is_write   <= rx_byte[0];
          default: ;
        endcase
    end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tx_byte     <= '0;
      tx_wr_en    <= 1'b0;
      tx_busy_d   <= 1'b0;
      resp_ready  <= 1'b0;
      rdata_q     <= '0;
      is_write_q  <= 1'b0;
      frames_done <= '0;
    end else begin
      tx_wr_en   <= 1'b0;
      tx_busy_d  <= tx_busy;
      resp_ready <= (tx_next == TX_IDLE);
      if (resp_hs) begin
        rdata_q    <= resp_rdata;
        is_write_q <= resp_is_write;
      end
      if (tx_state == TX_SEND_DATA && !tx_busy) begin
        tx_byte  <= rdata_q;
        tx_wr_en <= 1'b1;
      end
      if (tx_state == TX_SEND_FLAGS && !tx_busy) begin
        tx_byte  <= {7'b0, is_write_q};
        tx_wr_en <= 1'b1;
      end
      if (tx_done) frames_done <= frames_done + 8'd1;
    end

`ifdef BRIDGE_FRAME_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] to_cnt;
  logic          counting;

  // byte0 may wait forever; only a started frame is subject to the idle limit
  assign counting = rx_state inside {RX_B1, RX_B2, RX_B3};
  assign timeout  = counting && !consume && (to_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      to_cnt    <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= timeout;
      if (!counting || consume || timeout) to_cnt <= '0;
      else                                 to_cnt <= to_cnt + 1'b1;
    end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout        = 1'b0;
  assign frame_err      = 1'b0;
`endif
endmodule

// File: tb/tb_bus_bridge_initiator_uart_link.sv
// Randomized scoreboard bench: frames in, requests/responses checked against queued expectations.
module tb_bus_bridge_initiator_uart_link;
  logic        clk = 1'b0;
  logic        rst_n, rx_ready, rx_ready_clr, tx_wr_en, tx_busy;
  logic [7:0]  rx_byte, tx_byte, req_wdata, resp_rdata, frames_done;
  logic        req_valid, req_ready, req_is_write, resp_valid, resp_ready, resp_is_write, frame_err;
  logic [15:0] req_addr;

  bus_bridge_initiator_uart_link #(.TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .rst_n(rst_n), .rx_byte(rx_byte), .rx_ready(rx_ready), .rx_ready_clr(rx_ready_clr),
    .tx_byte(tx_byte), .tx_wr_en(tx_wr_en), .tx_busy(tx_busy),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_is_write(req_is_write), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_is_write(resp_is_write), .frame_err(frame_err),
    .frames_done(frames_done));

  always #5 clk = ~clk;

  typedef struct packed {logic [15:0] addr; logic [7:0] wdata; logic iw;} req_t;
  req_t       exp_req[$];
  logic [7:0] exp_tx[$];
  logic       jobs[$];
  int checks = 0, errors = 0;
  int cyc = 0, n_sent = 0, done_total = 0, consumed = 0;
  bit abort = 0, to_expected = 0, to_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic miss(input string nm);
    checks++;
    errors++;
    $display("FAIL %s got=nothing-expected want=queued-entry (cycle %0d)", nm, cyc);
  endtask

  // uart RX side: hold the byte until the bridge pulses rx_ready_clr
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_byte = b;
    rx_ready = 1'b1;
    do begin @(negedge clk); n++; end while (!rx_ready_clr && n < 3000);
    if (!rx_ready_clr) begin
      chk("rx_consume_timeout", 32'(rx_ready_clr), 1);
      abort = 1;
    end
    rx_ready = 1'b0;
  endtask

  task automatic send_frame();
    req_t r;
    logic [7:0] flags;
    r.addr = 16'($urandom);
    r.wdata = 8'($urandom);
    flags = 8'($urandom);
    r.iw = flags[0];
    exp_req.push_back(r);
    send_byte(r.addr[7:0]);
    repeat ($urandom_range(0, 2)) @(negedge clk);
    send_byte(r.addr[15:8]);
    repeat ($urandom_range(0, 2)) @(negedge clk);
    send_byte(r.wdata);
    repeat ($urandom_range(0, 2)) @(negedge clk);
    send_byte(flags);
    n_sent++;
  endtask

  task automatic run_txns(input int n);
    for (int i = 0; i < n && !abort; i++) send_frame();
  endtask

  task automatic wait_done(input int tgt);
    int n = 0;
    while (done_total < tgt && n < 20000) begin @(negedge clk); n++; end
    chk("all_frames_done", done_total, tgt);
  endtask

  task automatic chk_reset_outputs();
    chk("reset_ctrl", {rx_ready_clr, tx_wr_en, req_valid, req_is_write, resp_ready, frame_err}, 0);
    chk("reset_data", {req_addr, tx_byte, req_wdata}, 0);
    chk("reset_count", frames_done, 0);
  endtask

  // Monitor / responder / uart TX model, all evaluated on the falling edge
  initial begin
    int  req_wait = 0, resp_delay = 0, busy_left = 0, hs_cyc = 0;
    bit  hs_req = 0, hs_resp = 0, tx_active = 0, tx_idx = 0, frm_chk = 0, iw;
    logic [7:0] rd;
    req_ready = 0; resp_valid = 0; resp_rdata = 0; resp_is_write = 0; tx_busy = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        req_ready = 0; resp_valid = 0; tx_busy = 0; busy_left = 0; req_wait = 0; resp_delay = 0;
        hs_req = 0; hs_resp = 0; tx_active = 0; tx_idx = 0; frm_chk = 0;
        consumed = 0; done_total = 0; jobs.delete();
      end else begin
        if (rx_ready_clr) begin
          consumed++;
          chk("rx_backpressure", 32'((consumed - 1) / 4 <= done_total), 1);
          if (consumed % 4 == 0) chk("req_valid_latency", 32'(req_valid), 1);
        end
        if (frame_err) begin
          chk("frame_err_expected", 32'(to_expected), 1);
          to_expected = 0; to_seen = 1;
          consumed = (consumed / 4) * 4;
        end
        if (hs_req) begin
          chk("req_valid_drop", 32'(req_valid), 0);
          req_ready = 0; hs_req = 0;
          req_wait = ($urandom_range(0, 7) == 0) ? 20 : $urandom_range(0, 3);
        end else if (req_valid) begin
          if (exp_req.size() == 0) miss("req_unexpected");
          else chk("req_fields", {req_addr, req_wdata, req_is_write}, 32'(exp_req[0]));
          if (req_wait == 0) begin
            req_ready = 1; hs_req = 1;
            if (exp_req.size() != 0) jobs.push_back(exp_req.pop_front().iw);
          end else req_wait--;
        end
        if (hs_resp) begin
          resp_valid = 0; hs_resp = 0;
        end else if (!resp_valid && jobs.size() > 0) begin
          if (resp_delay > 0) resp_delay--;
          else begin
            iw = jobs.pop_front();
            rd = iw ? 8'h00 : 8'($urandom);
            resp_valid = 1; resp_rdata = rd; resp_is_write = iw;
            exp_tx.push_back(rd);
            exp_tx.push_back({7'b0, iw});
            resp_delay = $urandom_range(0, 4);
          end
        end
        if (resp_valid && !hs_resp) begin
          if (resp_ready) begin hs_resp = 1; tx_active = 1; hs_cyc = cyc + 1; end
        end else if (tx_active) chk("resp_ready_busy", 32'(resp_ready), 0);
        if (tx_wr_en) begin
          chk("tx_while_busy", 32'(tx_busy), 0);
          if (!tx_idx) chk("tx_latency", cyc, hs_cyc + 1);
          if (exp_tx.size() == 0) miss("tx_unexpected");
          else chk("tx_byte", tx_byte, exp_tx.pop_front());
          tx_busy = 1; busy_left = $urandom_range(1, 5);
        end else if (busy_left > 0) begin
          busy_left--;
          if (busy_left == 0) begin
            tx_busy = 0;
            if (tx_idx) begin tx_active = 0; done_total++; frm_chk = 1; end
            tx_idx = ~tx_idx;
          end
        end else if (frm_chk) begin
          chk("frames_done", frames_done, 32'(done_total % 256));
          frm_chk = 0;
        end
      end
    end
  end

  initial begin
    int n;
    rst_n = 0; rx_ready = 0; rx_byte = 0;
    repeat (3) @(negedge clk);
    chk_reset_outputs();
    rst_n = 1;
    run_txns(20);
    wait_done(n_sent);
`ifdef BRIDGE_FRAME_TIMEOUT_EN
    to_expected = 1;
    send_byte(8'($urandom));
    send_byte(8'($urandom));
    repeat (130) @(negedge clk);
    chk("frame_err_seen", 32'(to_seen), 1);
    run_txns(3);
    wait_done(n_sent);
`endif
    // reset while the rdata byte is on the wire
    send_frame();
    n = 0;
    while (!tx_busy && n < 2000) begin @(negedge clk); n++; end
    chk("reach_tx_wait_data", 32'(tx_busy), 1);
    rst_n = 0;
    repeat (3) @(negedge clk);
    chk_reset_outputs();
    exp_req.delete(); exp_tx.delete();
    n_sent = 0; to_expected = 0;
    rst_n = 1;
    repeat (5) @(negedge clk);
    chk("post_reset_quiet", {rx_ready_clr, tx_wr_en, req_valid, frames_done}, 0);
    run_txns(260);
    wait_done(n_sent);
    repeat (5) @(negedge clk);
    chk("req_queue_empty", exp_req.size(), 0);
    chk("tx_queue_empty", exp_tx.size(), 0);
    chk("frames_done_wrap", frames_done, 32'(n_sent % 256));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
